spi_reg_access_arbiter: RTL and testbench

- Shares one multi-byte SPI master with chip-select handling between NUM_REQ register-access requesters.
- Each granted request becomes a fixed 2-byte SPI transaction:
  - byte0 = {rw, addr[6:0]}.
  - byte1 = write data, or 0x00 dummy for a read.
- On a read, the byte received during byte1 is returned as read data.
- Sits between control-plane logic (config FSMs, CPU bridge) and the SPI master; drives that master's tx_count/tx_byte/tx_en port and consumes its rx_byte/rx_en/rx_count outputs.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/spi_reg_access_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_spi_reg_access_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-access arbiter and its round-robin helper.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        GAP,
        DATA,
        RX,
        ACK
    } state_e;

    localparam logic       READ_BIT    = 1'b1;
    localparam logic [7:0] DUMMY_BYTE  = 8'h00;
    localparam int         FRAME_BYTES = 2;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the pointer, wrapping.
module rr_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_valid_o
);

    always_comb begin
        int j;
        j             = 0;
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!grant_valid_o && req_i[j]) begin
                grant_valid_o = 1'b1;
                grant_o[j]    = 1'b1;
                grant_idx_o   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/spi_reg_access_arbiter.sv
// Shares one multi-byte SPI master between NUM_REQ register-access requesters,
// turning each grant into a 2-byte {rw,addr} + data frame with a completion timeout.
module spi_reg_access_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int CNT_W        = 2,
    parameter int TIMEOUT_CLKS = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [CNT_W-1:0]     m_tx_count,
    output logic [7:0]           m_tx_byte,
    output logic                 m_tx_en,
    input  logic                 m_tx_ready,
    input  logic [7:0]           m_rx_byte,
    input  logic                 m_rx_en,
    input  logic [CNT_W-1:0]     m_rx_count
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 rw_q, rw_d;
    logic [6:0]           addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [TO_W-1:0]      tmo_q, tmo_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 tx_en_q, tx_en_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic [CNT_W-1:0]     tx_count_q, tx_count_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic                 counting;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i         (req_valid),
        .ptr_i         (ptr_q),
        .grant_o       (arb_grant),
        .grant_idx_o   (arb_idx),
        .grant_valid_o (arb_valid)
    );

    assign counting = (state_q == CMD) || (state_q == GAP) ||
                      (state_q == DATA) || (state_q == RX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tmo_q      <= '0;
            ack_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            tx_en_q    <= 1'b0;
            tx_byte_q  <= '0;
            tx_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tmo_q      <= tmo_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            tx_en_q    <= tx_en_d;
            tx_byte_q  <= tx_byte_d;
            tx_count_q <= tx_count_d;
        end
    end

    // Completion (normal or timeout) raises the ack on entry to ACK, so the requester
    // has dropped req_valid by the time IDLE arbitrates again.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tmo_d      = tmo_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        busy_d     = busy_q;
        tx_en_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        tx_count_d = tx_count_q;

        if (counting && (tmo_q == '0)) begin
            ack_d      = gnt_q;
            err_d      = 1'b1;
            busy_d     = 1'b0;
            tx_count_d = '0;
            state_d    = ACK;
        end else begin
            if (counting) begin
                tmo_d = tmo_q - TO_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        gnt_d      = arb_grant;
                        rw_d       = req_rw[arb_idx];
                        addr_d     = req_addr[7*int'(arb_idx) +: 7];
                        wdata_d    = req_wdata[8*int'(arb_idx) +: 8];
                        ptr_d      = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                        busy_d     = 1'b1;
                        tmo_d      = TO_W'(TIMEOUT_CLKS);
                        tx_count_d = CNT_W'(FRAME_BYTES);
                        state_d    = CMD;
                    end
                end
                CMD: begin
                    if (m_tx_ready) begin
                        tx_en_d   = 1'b1;
                        tx_byte_d = {rw_q, addr_q};
                        state_d   = GAP;
                    end
                end
                GAP: begin
                    state_d = DATA;
                end
                DATA: begin
                    if (m_tx_ready) begin
                        tx_en_d   = 1'b1;
                        tx_byte_d = (rw_q == READ_BIT) ? DUMMY_BYTE : wdata_q;
                        state_d   = RX;
                    end
                end
                RX: begin
                    if (m_rx_en && (m_rx_count == CNT_W'(1))) begin
                        if (rw_q == READ_BIT) begin
                            rdata_d = m_rx_byte;
                        end
                        ack_d      = gnt_q;
                        err_d      = 1'b0;
                        busy_d     = 1'b0;
                        tx_count_d = '0;
                        state_d    = ACK;
                    end
                end
                ACK: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign req_ack    = ack_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;
    assign busy       = busy_q;
    assign m_tx_en    = tx_en_q;
    assign m_tx_byte  = tx_byte_q;
    assign m_tx_count = tx_count_q;

endmodule

// File: tb/tb_spi_reg_access_arbiter.sv
// Directed bench for spi_reg_access_arbiter with a byte-level SPI master model.
module tb_spi_reg_access_arbiter;

    localparam int NUM_REQ      = 2;
    localparam int CNT_W        = 2;
    localparam int TIMEOUT_CLKS = 20;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_rw = '0;
    logic [7*NUM_REQ-1:0] req_addr = '0;
    logic [8*NUM_REQ-1:0] req_wdata = '0;
    logic [NUM_REQ-1:0]   req_ack;
    logic [7:0]           rsp_rdata;
    logic                 rsp_err;
    logic                 busy;
    logic [CNT_W-1:0]     m_tx_count;
    logic [7:0]           m_tx_byte;
    logic                 m_tx_en;
    logic                 m_tx_ready;
    logic [7:0]           m_rx_byte;
    logic                 m_rx_en;
    logic [CNT_W-1:0]     m_rx_count;

    logic                 stall = 1'b0;
    logic [7:0]           misoByte1 = 8'h00;
    logic [2:0]           timer;
    logic                 csN;
    logic [CNT_W-1:0]     rxIdx;
    logic [CNT_W-1:0]     curTxCount;

    int                   frameNum = 0;
    int                   byteInFrame = 0;
    int                   overrun = 0;
    int                   doubleTx = 0;
    logic                 prevTxEn = 1'b0;
    logic [7:0]           mosiB0 = 8'h00;
    logic [7:0]           mosiB1 = 8'h00;
    logic [CNT_W-1:0]     txCountAtB0 = '0;
    int                   ackCnt [NUM_REQ];

    int                   nChecks = 0;
    int                   nFail = 0;

    always #5 clk = ~clk;

    spi_reg_access_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .CNT_W        (CNT_W),
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ack    (req_ack),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .m_tx_count (m_tx_count),
        .m_tx_byte  (m_tx_byte),
        .m_tx_en    (m_tx_en),
        .m_tx_ready (m_tx_ready),
        .m_rx_byte  (m_rx_byte),
        .m_rx_en    (m_rx_en),
        .m_rx_count (m_rx_count)
    );

    // Master model: each byte takes three cycles, CS_n drops on the first byte of a
    // frame and rises after the last received byte.
    assign m_tx_ready = !stall && (timer == 3'd0) && !m_tx_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer      <= 3'd0;
            csN        <= 1'b1;
            rxIdx      <= '0;
            curTxCount <= '0;
            m_rx_en    <= 1'b0;
            m_rx_byte  <= 8'h00;
            m_rx_count <= '0;
        end else begin
            m_rx_en <= 1'b0;
            if (m_tx_en) begin
                timer <= 3'd3;
                if (csN) begin
                    csN        <= 1'b0;
                    rxIdx      <= '0;
                    curTxCount <= m_tx_count;
                end
            end else if (timer > 3'd1) begin
                timer <= timer - 3'd1;
            end else if (timer == 3'd1) begin
                timer      <= 3'd0;
                m_rx_en    <= 1'b1;
                m_rx_count <= rxIdx;
                m_rx_byte  <= (rxIdx == '0) ? 8'hFF : misoByte1;
                rxIdx      <= rxIdx + 1'b1;
                if (rxIdx + 1'b1 == curTxCount) begin
                    csN <= 1'b1;
                end
            end
        end
    end

    // Bus monitor: logs MOSI bytes per CS window, transmit-pulse spacing and acks.
    initial begin
        for (int i = 0; i < NUM_REQ; i++) ackCnt[i] = 0;
    end

    always @(posedge clk) begin
        prevTxEn <= m_tx_en;
        if (m_tx_en && prevTxEn) doubleTx <= doubleTx + 1;
        if (m_tx_en) begin
            if (csN) begin
                frameNum    <= frameNum + 1;
                byteInFrame <= 1;
                mosiB0      <= m_tx_byte;
                txCountAtB0 <= m_tx_count;
            end else begin
                if (byteInFrame != 1) overrun <= overrun + 1;
                byteInFrame <= 2;
                mosiB1      <= m_tx_byte;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ack[i]) ackCnt[i] <= ackCnt[i] + 1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Raises one request, waits (bounded) for its ack, returns ack status, grant-to-ack
    // latency and the response sampled in the ack cycle, then releases the request.
    task automatic applyStimulus(input int idx, input logic rw, input logic [6:0] addr,
                                 input logic [7:0] wdata, output logic gotAck,
                                 output int lat, output logic errO, output logic [7:0] rdataO);
        int busyAt;
        busyAt = -1;
        gotAck = 1'b0;
        lat    = -1;
        errO   = 1'bx;
        rdataO = 8'hxx;
        req_rw[idx]            = rw;
        req_addr[idx*7 +: 7]   = addr;
        req_wdata[idx*8 +: 8]  = wdata;
        req_valid[idx]         = 1'b1;
        for (int c = 0; c < 100 && !gotAck; c++) begin
            @(negedge clk);
            if (busy && busyAt < 0) busyAt = c;
            if (req_ack[idx]) begin
                gotAck = 1'b1;
                lat    = c - busyAt;
                errO   = rsp_err;
                rdataO = rsp_rdata;
            end
        end
        req_valid[idx] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic       ok;
        logic       err;
        logic [7:0] rd;
        int         lat;
        int         f0;
        int         a0;
        int         a1;
        int         nAck;
        int         order [8];
        int         remaining [NUM_REQ];
        logic       sawTx;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy",     32'(busy),       32'd0);
        checkOutput("reset_ack",      32'(req_ack),    32'd0);
        checkOutput("reset_rdata",    32'(rsp_rdata),  32'h00);
        checkOutput("reset_err",      32'(rsp_err),    32'd0);
        checkOutput("reset_tx_en",    32'(m_tx_en),    32'd0);
        checkOutput("reset_tx_byte",  32'(m_tx_byte),  32'h00);
        checkOutput("reset_tx_count", 32'(m_tx_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write from requester 0
        f0 = frameNum;
        a0 = ackCnt[0];
        applyStimulus(0, 1'b0, 7'h12, 8'hA5, ok, lat, err, rd);
        repeat (3) @(negedge clk);
        checkOutput("wr_ack",        32'(ok),          32'd1);
        checkOutput("wr_err",        32'(err),         32'd0);
        checkOutput("wr_mosi0",      32'(mosiB0),      32'h12);
        checkOutput("wr_mosi1",      32'(mosiB1),      32'hA5);
        checkOutput("wr_one_frame",  32'(frameNum - f0), 32'd1);
        checkOutput("wr_ack_once",   32'(ackCnt[0] - a0), 32'd1);
        checkOutput("wr_tx_count",   32'(txCountAtB0), 32'd2);
        checkOutput("wr_idle_busy",  32'(busy),        32'd0);

        // Single read from requester 1
        misoByte1 = 8'h3C;
        f0 = frameNum;
        applyStimulus(1, 1'b1, 7'h05, 8'hEE, ok, lat, err, rd);
        checkOutput("rd_ack",       32'(ok),       32'd1);
        checkOutput("rd_rdata",     32'(rd),       32'h3C);
        checkOutput("rd_err",       32'(err),      32'd0);
        checkOutput("rd_mosi0",     32'(mosiB0),   32'h85);
        checkOutput("rd_mosi1",     32'(mosiB1),   32'h00);
        checkOutput("rd_one_frame", 32'(frameNum - f0), 32'd1);

        // Both requesters held for four writes each: strict alternation from pointer 0
        req_rw             = 2'b00;
        req_addr[6:0]      = 7'h21;
        req_addr[13:7]     = 7'h33;
        req_wdata[7:0]     = 8'h10;
        req_wdata[15:8]    = 8'h20;
        remaining[0]       = 4;
        remaining[1]       = 4;
        nAck               = 0;
        for (int i = 0; i < 8; i++) order[i] = -1;
        req_valid = 2'b11;
        for (int c = 0; c < 400 && nAck < 8; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ack[i] && nAck < 8) begin
                    order[nAck] = i;
                    nAck++;
                    remaining[i]--;
                    if (remaining[i] == 0) req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        checkOutput("rr_total_acks", 32'(nAck),     32'd8);
        checkOutput("rr_order0",     32'(order[0]), 32'd0);
        checkOutput("rr_order1",     32'(order[1]), 32'd1);
        checkOutput("rr_order2",     32'(order[2]), 32'd0);
        checkOutput("rr_order3",     32'(order[3]), 32'd1);
        checkOutput("rr_order7",     32'(order[7]), 32'd1);
        checkOutput("rr_last_mosi0", 32'(mosiB0),   32'h33);
        checkOutput("rr_last_mosi1", 32'(mosiB1),   32'h20);

        // Stalled master: timeout ack 21 cycles after grant, read data untouched
        stall = 1'b1;
        f0 = frameNum;
        applyStimulus(0, 1'b0, 7'h40, 8'h11, ok, lat, err, rd);
        checkOutput("to_ack",      32'(ok),   32'd1);
        checkOutput("to_latency",  32'(lat),  32'd21);
        checkOutput("to_err",      32'(err),  32'd1);
        checkOutput("to_rdata",    32'(rd),   32'h3C);
        checkOutput("to_no_frame", 32'(frameNum - f0), 32'd0);
        stall = 1'b0;
        misoByte1 = 8'h77;
        applyStimulus(1, 1'b1, 7'h0A, 8'h00, ok, lat, err, rd);
        checkOutput("post_to_ack",   32'(ok),     32'd1);
        checkOutput("post_to_err",   32'(err),    32'd0);
        checkOutput("post_to_rdata", 32'(rd),     32'h77);
        checkOutput("post_to_mosi0", 32'(mosiB0), 32'h8A);

        // Reset asserted while the DATA byte is pending
        misoByte1 = 8'h5A;
        a0 = ackCnt[0];
        a1 = ackCnt[1];
        req_rw[1]        = 1'b1;
        req_addr[13:7]   = 7'h06;
        req_valid[1]     = 1'b1;
        sawTx = 1'b0;
        for (int c = 0; c < 50 && !sawTx; c++) begin
            @(negedge clk);
            if (m_tx_en) sawTx = 1'b1;
        end
        checkOutput("rst_saw_cmd", 32'(sawTx), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy",   32'(busy),      32'd0);
        checkOutput("rst_tx_en",  32'(m_tx_en),   32'd0);
        checkOutput("rst_ack",    32'(req_ack),   32'd0);
        checkOutput("rst_rdata",  32'(rsp_rdata), 32'h00);
        repeat (2) @(negedge clk);
        checkOutput("rst_no_ack", 32'((ackCnt[0] - a0) + (ackCnt[1] - a1)), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1, 1'b1, 7'h06, 8'h00, ok, lat, err, rd);
        checkOutput("rst_fresh_ack",   32'(ok),     32'd1);
        checkOutput("rst_fresh_rdata", 32'(rd),     32'h5A);
        checkOutput("rst_fresh_mosi0", 32'(mosiB0), 32'h86);

        // Back-to-back reads from requester 0
        f0 = frameNum;
        misoByte1 = 8'hC3;
        applyStimulus(0, 1'b1, 7'h7F, 8'h00, ok, lat, err, rd);
        checkOutput("b2b_rdata0", 32'(rd), 32'hC3);
        misoByte1 = 8'h3D;
        applyStimulus(0, 1'b1, 7'h01, 8'h00, ok, lat, err, rd);
        checkOutput("b2b_rdata1", 32'(rd),     32'h3D);
        checkOutput("b2b_mosi0",  32'(mosiB0), 32'h81);
        checkOutput("b2b_frames", 32'(frameNum - f0), 32'd2);
        checkOutput("no_double_tx_en", 32'(doubleTx), 32'd0);
        checkOutput("no_frame_overrun", 32'(overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
